countdown_min_sec: RTL and testbench



---
 rtl/countdown_min_sec_pkg.sv | 25 ++
 rtl/countdown_min_sec_if.sv | 29 ++
 rtl/countdown_min_sec_bcd_down_digit_pair.sv | 35 +++
 rtl/countdown_min_sec.sv | 121 ++++++++++++
 tb/tb_countdown_min_sec.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_min_sec_pkg.sv
// rtl/countdown_min_sec_pkg.sv - shared timer constants, types and digit clamping helpers
package countdown_min_sec_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] TENS_MAX  = 4'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    function automatic logic [3:0] clamp_tens(input logic [3:0] d);
        return (d > TENS_MAX) ? TENS_MAX : d;
    endfunction

    function automatic logic [3:0] clamp_units(input logic [3:0] d);
        return (d > UNITS_MAX) ? UNITS_MAX : d;
    endfunction

endpackage

// File: rtl/countdown_min_sec_if.sv
// rtl/countdown_min_sec_if.sv - control, setting and display bundle of the countdown timer
interface countdown_min_sec_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] set_m1;
    logic [3:0] set_m0;
    logic [3:0] set_s1;
    logic [3:0] set_s0;
    logic [3:0] out_m1;
    logic [3:0] out_m0;
    logic [3:0] out_s1;
    logic [3:0] out_s0;
    logic       borrow;
    logic       done;
    logic       alarm;
    logic       running;

    modport master (
        output tick, load, start, pause, set_m1, set_m0, set_s1, set_s0,
        input  out_m1, out_m0, out_s1, out_s0, borrow, done, alarm, running
    );

    modport slave (
        input  tick, load, start, pause, set_m1, set_m0, set_s1, set_s0,
        output out_m1, out_m0, out_s1, out_s0, borrow, done, alarm, running
    );
endinterface

// File: rtl/countdown_min_sec_bcd_down_digit_pair.sv
// rtl/countdown_min_sec_bcd_down_digit_pair.sv - combinational BCD tens:units decrementer
module bcd_down_digit_pair
    import countdown_min_sec_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       dec,
    output logic [3:0] next_tens,
    output logic [3:0] next_units,
    output logic       zero,
    output logic       borrow_out
);

    assign zero = (tens == 4'd0) && (units == 4'd0);

    always_comb begin
        next_tens  = tens;
        next_units = units;
        borrow_out = 1'b0;
        if (dec) begin
            if (units != 4'd0) begin
                next_units = units - 4'd1;
            end else if (tens != 4'd0) begin
                next_units = UNITS_MAX;
                next_tens  = tens - 4'd1;
            end else begin
                // 00 wraps to the top of the range and asks the next pair for a borrow
                next_units = UNITS_MAX;
                next_tens  = TENS_MAX;
                borrow_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_min_sec.sv
// rtl/countdown_min_sec.sv - BCD mm:ss countdown timer with borrow, done and timed alarm
module countdown_min_sec
    import countdown_min_sec_pkg::*;
#(
    parameter int ALARM_TICKS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    countdown_min_sec_if.slave        bus
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS - 1);

    logic [1:0] state, nx_state;
    logic [3:0] alarm_cnt, nx_alarm_cnt;
    bcd_pair_t  min_q, sec_q, nx_min, nx_sec;
    logic       nx_borrow, nx_done;

    logic [3:0] sec_nt, sec_nu, min_nt, min_nu;
    logic       sec_zero, sec_bout, min_zero, min_bout;

    bcd_down_digit_pair u_sec (
        .tens       (sec_q.tens),
        .units      (sec_q.units),
        .dec        (1'b1),
        .next_tens  (sec_nt),
        .next_units (sec_nu),
        .zero       (sec_zero),
        .borrow_out (sec_bout)
    );

    bcd_down_digit_pair u_min (
        .tens       (min_q.tens),
        .units      (min_q.units),
        .dec        (sec_bout),
        .next_tens  (min_nt),
        .next_units (min_nu),
        .zero       (min_zero),
        .borrow_out (min_bout)
    );

    always_comb begin
        nx_state     = state;
        nx_alarm_cnt = alarm_cnt;
        nx_min       = min_q;
        nx_sec       = sec_q;
        nx_borrow    = 1'b0;
        nx_done      = 1'b0;
        if (bus.load) begin
            nx_min.tens  = clamp_tens(bus.set_m1);
            nx_min.units = clamp_units(bus.set_m0);
            nx_sec.tens  = clamp_tens(bus.set_s1);
            nx_sec.units = clamp_units(bus.set_s0);
            nx_state     = ST_IDLE;
            nx_alarm_cnt = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !(min_zero && sec_zero))
                        nx_state = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        nx_state = ST_PAUSE;
                    end else if (bus.tick && !min_bout) begin
                        // min_bout only fires from 00:00, where there is nothing left to count
                        nx_sec    = '{tens: sec_nt, units: sec_nu};
                        nx_min    = '{tens: min_nt, units: min_nu};
                        nx_borrow = sec_bout;
                        if (min_zero && sec_q.tens == 4'd0 && sec_q.units == 4'd1) begin
                            nx_done  = 1'b1;
                            nx_state = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start)
                        nx_state = ST_RUN;
                end
                default: begin
                    if (bus.tick) begin
                        if (alarm_cnt >= ALARM_LAST) begin
                            nx_state     = ST_IDLE;
                            nx_alarm_cnt = 4'd0;
                        end else begin
                            nx_alarm_cnt = alarm_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            alarm_cnt   <= 4'd0;
            min_q       <= '0;
            sec_q       <= '0;
            bus.borrow  <= 1'b0;
            bus.done    <= 1'b0;
            bus.alarm   <= 1'b0;
            bus.running <= 1'b0;
        end else begin
            state       <= nx_state;
            alarm_cnt   <= nx_alarm_cnt;
            min_q       <= nx_min;
            sec_q       <= nx_sec;
            bus.borrow  <= nx_borrow;
            bus.done    <= nx_done;
            bus.alarm   <= (nx_state == ST_DONE);
            bus.running <= (nx_state == ST_RUN);
        end
    end

    assign bus.out_m1 = min_q.tens;
    assign bus.out_m0 = min_q.units;
    assign bus.out_s1 = sec_q.tens;
    assign bus.out_s0 = sec_q.units;

endmodule

// File: tb/tb_countdown_min_sec.sv
// tb/tb_countdown_min_sec.sv - directed self-checking bench for countdown_min_sec
module tb_countdown_min_sec;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    countdown_min_sec_if bus ();

    countdown_min_sec #(.ALARM_TICKS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] value();
        return {bus.out_m1, bus.out_m0, bus.out_s1, bus.out_s0};
    endfunction

    task automatic step(input logic t, input logic l, input logic s, input logic p);
        bus.tick  = t;
        bus.load  = l;
        bus.start = s;
        bus.pause = p;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.set_m1 = v[15:12];
        bus.set_m0 = v[11:8];
        bus.set_s1 = v[7:4];
        bus.set_s0 = v[3:0];
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if ({value(), bus.borrow, bus.done, bus.alarm, bus.running} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b%b%b%b want 0000/0000", value(),
                     bus.borrow, bus.done, bus.alarm, bus.running);
        end
    endtask

    task automatic test_borrow();
        logic [15:0] exp_v [3];
        logic        exp_b [3];
        exp_v[0] = 16'h0101; exp_b[0] = 1'b0;
        exp_v[1] = 16'h0100; exp_b[1] = 1'b0;
        exp_v[2] = 16'h0059; exp_b[2] = 1'b1;
        do_load(16'h0102);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.running !== 1'b1) begin
            errors++;
            $display("FAIL borrow_running: got %b want 1", bus.running);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (value() !== exp_v[i] || bus.borrow !== exp_b[i] || bus.running !== 1'b1) begin
                errors++;
                $display("FAIL borrow_tick%0d: got %h b=%b r=%b want %h b=%b r=1", i, value(),
                         bus.borrow, bus.running, exp_v[i], exp_b[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL borrow_one_cycle: got %b want 0", bus.borrow);
        end
    endtask

    task automatic test_done();
        do_load(16'h0002);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0001 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_early: got %h d=%b want 0001 d=0", value(), bus.done);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0000 || bus.done !== 1'b1 || bus.alarm !== 1'b1 ||
            bus.running !== 1'b0 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL done_edge: got %h d=%b a=%b r=%b b=%b want 0000 d=1 a=1 r=0 b=0",
                     value(), bus.done, bus.alarm, bus.running, bus.borrow);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.done !== 1'b0 || bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: got d=%b a=%b r=%b want d=0 a=1 r=0",
                     bus.done, bus.alarm, bus.running);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_hold: got %b want 1", bus.alarm);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.alarm !== 1'b0 || bus.running !== 1'b0 || value() !== 16'h0000) begin
            errors++;
            $display("FAIL alarm_end: got a=%b r=%b %h want a=0 r=0 0000", bus.alarm,
                     bus.running, value());
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.running !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_zero_start: got r=%b d=%b want r=0 d=0", bus.running, bus.done);
        end
    endtask

    task automatic test_pause();
        do_load(16'h1000);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0959 || bus.borrow !== 1'b1) begin
            errors++;
            $display("FAIL pause_first_tick: got %h b=%b want 0959 b=1", value(), bus.borrow);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (value() !== 16'h0959 || bus.running !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold%0d: got %h r=%b want 0959 r=0", i, value(), bus.running);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0958 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got %h r=%b want 0958 r=1", value(), bus.running);
        end
    endtask

    task automatic test_clamp();
        bus.set_m1 = 4'd7;
        bus.set_m0 = 4'd12;
        bus.set_s1 = 4'd9;
        bus.set_s0 = 4'd15;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h5959 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL clamp: got %h r=%b want 5959 r=0", value(), bus.running);
        end
        do_load(16'h0000);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b0 || bus.done !== 1'b0 || value() !== 16'h0000) begin
            errors++;
            $display("FAIL zero_start: got %h r=%b d=%b want 0000 r=0 d=0", value(),
                     bus.running, bus.done);
        end
    endtask

    task automatic test_load_tick();
        do_load(16'h0500);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        bus.set_m1 = 4'd0;
        bus.set_m0 = 4'd2;
        bus.set_s1 = 4'd3;
        bus.set_s0 = 4'd0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0230 || bus.running !== 1'b0 || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL load_tick: got %h r=%b b=%b want 0230 r=0 b=0", value(),
                     bus.running, bus.borrow);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0230) begin
            errors++;
            $display("FAIL idle_tick: got %h want 0230", value());
        end
    endtask

    task automatic test_back_to_back();
        do_load(16'h0010);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (value() !== 16'h0010 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL tick_pause: got %h r=%b want 0010 r=0", value(), bus.running);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (value() !== 16'h0010 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL start_tick: got %h r=%b want 0010 r=1", value(), bus.running);
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(16'h0317);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({value(), bus.borrow, bus.done, bus.alarm, bus.running} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b%b%b%b want 0000/0000", value(),
                     bus.borrow, bus.done, bus.alarm, bus.running);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (value() !== 16'h0000 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tick: got %h r=%b want 0000 r=0", value(), bus.running);
        end
        do_load(16'h0317);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (value() !== 16'h0316 || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run: got %h r=%b want 0316 r=1", value(), bus.running);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus.tick   = 1'b0;
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.set_m1 = 4'd0;
        bus.set_m0 = 4'd0;
        bus.set_s1 = 4'd0;
        bus.set_s0 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_borrow();
        test_done();
        test_pause();
        test_clamp();
        test_load_tick();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
